// File: rtl/serial_fs.sv
// serial_fs - bit-serial full subtractor.
//
// Computes diff = a - b - bin (modulo 2^WIDTH) one bit per clock, LSB first.
// One full-subtractor cell and one borrow flip-flop do the arithmetic.
// Operands are captured when start is accepted in IDLE. The parallel result
// and the final borrow are published together on the last RUN edge.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   start     operation request, only sampled in IDLE
//   a, b      minuend / subtrahend, captured on the accepting edge
//   bin       borrow-in, captured on the accepting edge
//   busy      high while bits are being processed (RUN)
//   done      one-cycle pulse when diff/bout have just been updated
//   diff      parallel difference, held until the next completion
//   bout      final borrow-out, held alongside diff
//   bit_diff  serial difference bit for the current index (RUN only)
//   bit_valid high in RUN, qualifies bit_diff

module serial_fs #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             bit_diff,
    output logic             bit_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             bnext;
    logic             last_bit;

    // Full-subtractor cell.
    // A borrow is generated when a=0,b=1. An incoming borrow propagates
    // when a==b.
    assign d        = a_sh[0] ^ b_sh[0] ^ br;
    assign bnext    = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    assign last_bit = (cnt == LAST_IDX);

    // The flags decode the registered state directly. As a result they are
    // glitch-free and drop at the same moment the asynchronous reset hits.
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign bit_valid = (state == RUN);
    assign bit_diff  = (state == RUN) ? d : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DONE always lasts exactly one cycle.
    // Because of that, a start held high gives one op every WIDTH+2 cycles.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (last_bit) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // diff/bout are loaded only on the final RUN edge, taking the last cell
    // output directly. Partial results therefore never appear on them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            res  <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        br   <= bin;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sh <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                    res  <= {d, res[WIDTH-1:1]};
                    br   <= bnext;
                    cnt  <= cnt + 1'b1;
                    if (last_bit) begin
                        diff <= {d, res[WIDTH-1:1]};
                        bout <= bnext;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_fs.sv
// tb_serial_fs - self-checking bench for serial_fs (WIDTH=8).
//
// The reference is plain 9-bit arithmetic: {bout,diff} = {0,a} - {0,b} - bin.
// The serial stream must reproduce the bits of that difference, LSB first.
// Each scenario task drives its own stimulus and compares inline.

module tb_serial_fs;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         bit_diff;
    logic         bit_valid;

    int total = 0;
    int bad   = 0;

    // Results of the most recent run_op call.
    int           op_busy;
    int           op_done;
    int           op_done_idx;
    logic [W-1:0] op_diff;
    logic         op_bout;
    logic [W-1:0] op_stream;
    logic         op_hold_ok;
    logic         op_bv_ok;

    serial_fs #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .bout      (bout),
        .bit_diff  (bit_diff),
        .bit_valid (bit_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] model_sub(input logic [W-1:0] ma,
                                             input logic [W-1:0] mb,
                                             input logic mbin);
        return {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    endfunction

    // Issues one start pulse, then observes 12 cycles on falling edges.
    // Sample 0 is the first RUN cycle. The operand inputs are scrambled
    // after the accepting edge because they must be don't-care there.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                          input logic tbin);
        logic [W-1:0] prev;
        @(negedge clk);
        prev  = diff;
        a     = ta;
        b     = tbv;
        bin   = tbin;
        start = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        a           = W'($urandom);
        b           = W'($urandom);
        bin         = 1'($urandom);
        op_busy     = 0;
        op_done     = 0;
        op_done_idx = -1;
        op_diff     = '0;
        op_bout     = 1'b0;
        op_stream   = '0;
        op_hold_ok  = 1'b1;
        op_bv_ok    = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            if (bit_valid !== busy) op_bv_ok = 1'b0;
            if (busy === 1'b1) begin
                if (op_busy < W) op_stream[op_busy] = bit_diff;
                op_busy++;
            end
            if (done === 1'b1) begin
                op_done++;
                op_done_idx = k;
                op_diff     = diff;
                op_bout     = bout;
            end else if (op_done == 0 && diff !== prev) begin
                op_hold_ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, bout, bit_valid, bit_diff, diff} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %0h expected 0",
                     {busy, done, bout, bit_valid, bit_diff, diff});
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL idle_after_reset: got busy/done=%b expected 00", {busy, done});
        end
    endtask

    task automatic test_basic;
        logic [W:0] exp;
        exp = model_sub(8'd100, 8'd37, 1'b0);
        run_op(8'd100, 8'd37, 1'b0);
        total++;
        if (op_busy != W) begin
            bad++; $display("[TB] FAIL basic_busy_cycles: got %0d expected %0d", op_busy, W);
        end
        total++;
        if (op_done != 1) begin
            bad++; $display("[TB] FAIL basic_done_count: got %0d expected 1", op_done);
        end
        total++;
        if (op_done_idx != W) begin
            bad++; $display("[TB] FAIL basic_latency: got %0d expected %0d", op_done_idx, W);
        end
        total++;
        if ({op_bout, op_diff} !== exp) begin
            bad++; $display("[TB] FAIL basic_result: got %0h expected %0h", {op_bout, op_diff}, exp);
        end
        total++;
        if (op_stream !== 8'h3F) begin
            bad++; $display("[TB] FAIL basic_stream: got %b expected %b", op_stream, 8'h3F);
        end
        total++;
        if (op_bv_ok !== 1'b1) begin
            bad++; $display("[TB] FAIL basic_bit_valid: got %b expected 1", op_bv_ok);
        end
    endtask

    // Follows the 100-37 op. The old 63 must hold through the whole RUN.
    task automatic test_hold;
        logic [W:0] exp;
        exp = model_sub(8'd5, 8'd10, 1'b0);
        run_op(8'd5, 8'd10, 1'b0);
        total++;
        if (op_hold_ok !== 1'b1) begin
            bad++; $display("[TB] FAIL hold_during_run: got %b expected 1", op_hold_ok);
        end
        total++;
        if ({op_bout, op_diff} !== exp || op_done_idx != W) begin
            bad++;
            $display("[TB] FAIL hold_update_at_done: got %0h@%0d expected %0h@%0d",
                     {op_bout, op_diff}, op_done_idx, exp, W);
        end
    endtask

    task automatic test_corners;
        logic [W-1:0] ca [4];
        logic [W-1:0] cb [4];
        logic         cbin [4];
        logic [W:0]   exp;
        ca = '{8'd5, 8'd0, 8'hFF, 8'd0};
        cb = '{8'd10, 8'd0, 8'hFF, 8'hFF};
        cbin = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            exp = model_sub(ca[i], cb[i], cbin[i]);
            run_op(ca[i], cb[i], cbin[i]);
            total++;
            if ({op_bout, op_diff} !== exp || op_stream !== exp[W-1:0]) begin
                bad++;
                $display("[TB] FAIL corner_%0d: got %0h stream %0h expected %0h",
                         i, {op_bout, op_diff}, op_stream, exp);
            end
        end
    endtask

    task automatic test_ignore_start;
        int           busy_n;
        int           done_n;
        int           first_done;
        logic [W-1:0] d_at;
        logic [W:0]   exp;
        exp = model_sub(8'd100, 8'd37, 1'b0);
        @(negedge clk);
        a = 8'd100; b = 8'd37; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_n = 0; done_n = 0; first_done = -1; d_at = '0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 2) begin start = 1'b1; a = 8'd1; b = 8'd2; end
            if (k == 3) start = 1'b0;
            if (k == 8) start = 1'b1;
            if (k == 9) start = 1'b0;
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) begin
                done_n++;
                d_at = diff;
                if (first_done < 0) first_done = k;
            end
        end
        total++;
        if (busy_n != W || done_n != 1) begin
            bad++;
            $display("[TB] FAIL ignore_start_counts: got busy=%0d done=%0d expected busy=%0d done=1",
                     busy_n, done_n, W);
        end
        total++;
        if (d_at !== exp[W-1:0] || first_done != W) begin
            bad++;
            $display("[TB] FAIL ignore_start_result: got %0d@%0d expected %0d@%0d",
                     d_at, first_done, exp[W-1:0], W);
        end
    endtask

    task automatic test_reset_mid_run;
        int         busy_n;
        int         done_n;
        logic [W:0] exp;
        @(negedge clk);
        a = 8'd100; b = 8'd37; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy, bit_valid, bit_diff, done, bout, diff} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_mid_run: got %0h expected 0",
                     {busy, bit_valid, bit_diff, done, bout, diff});
        end
        @(negedge clk);
        rst = 1'b0;
        busy_n = 0; done_n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) done_n++;
        end
        total++;
        if (busy_n != 0 || done_n != 0) begin
            bad++;
            $display("[TB] FAIL reset_abort: got busy=%0d done=%0d expected 0 0", busy_n, done_n);
        end
        exp = model_sub(8'd200, 8'd55, 1'b0);
        run_op(8'd200, 8'd55, 1'b0);
        total++;
        if ({op_bout, op_diff} !== exp || op_done != 1) begin
            bad++;
            $display("[TB] FAIL after_reset_op: got %0h done=%0d expected %0h done=1",
                     {op_bout, op_diff}, op_done, exp);
        end
    endtask

    task automatic test_back_to_back;
        int         done_n;
        int         last;
        logic [W:0] exp;
        @(negedge clk);
        a   = W'($urandom);
        b   = W'($urandom);
        bin = 1'($urandom);
        exp = model_sub(a, b, bin);
        start = 1'b1;
        done_n = 0; last = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_n++;
                if (last >= 0) begin
                    total++;
                    if (k - last != W + 2) begin
                        bad++;
                        $display("[TB] FAIL b2b_period: got %0d expected %0d", k - last, W + 2);
                    end
                end
                last = k;
                total++;
                if ({bout, diff} !== exp) begin
                    bad++;
                    $display("[TB] FAIL b2b_result: got %0h expected %0h", {bout, diff}, exp);
                end
            end
        end
        start = 1'b0;
        total++;
        if (done_n != 3) begin
            bad++; $display("[TB] FAIL b2b_done_count: got %0d expected 3", done_n);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_random;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rbin;
        logic [W:0]   exp;
        int           dones;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom);
            exp  = model_sub(ra, rb, rbin);
            run_op(ra, rb, rbin);
            dones += op_done;
            total++;
            if ({op_bout, op_diff} !== exp || op_stream !== exp[W-1:0]) begin
                bad++;
                $display("[TB] FAIL random_%0d result: a=%0d b=%0d bin=%0d got %0h stream %0h expected %0h",
                         i, ra, rb, rbin, {op_bout, op_diff}, op_stream, exp);
            end
            total++;
            if (op_busy != W) begin
                bad++;
                $display("[TB] FAIL random_%0d busy_cycles: got %0d expected %0d", i, op_busy, W);
            end
        end
        total++;
        if (dones != 30) begin
            bad++; $display("[TB] FAIL random_done_count: got %0d expected 30", dones);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_hold;
        test_corners;
        test_ignore_start;
        test_reset_mid_run;
        test_back_to_back;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
